// File: rtl/frame_bit_timer_pkg.sv
// Shared types and helpers for the frame bit timer.
// Holds the FSM state encoding and the width helpers used to size the
// bit counter and the bit index.
package frame_bit_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BIT  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Largest of three integers.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/frame_bit_timer_mod_counter.sv
// Modulo counter for the frame bit timer.
// Counts 0..last while enabled and wraps to 0 after last; clr has priority
// over en. The terminal value is an input so one counter can serve both the
// bit period and the inter-frame gap.
module mod_counter
    import frame_bit_timer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_reg;

    // Count register: clear, wrap at the terminal value, otherwise increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            if (cnt_reg == last) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + ONE;
            end
        end
    end

    assign cnt = cnt_reg;
    assign tc  = (cnt_reg == last);

endmodule

// File: rtl/frame_bit_timer.sv
// Frame bit timer: on start, produces BITS_PER_FRAME bit periods of
// BIT_CYCLES cycles each, followed by IDLE_CYCLES gap cycles.
// Optional build macro FRAME_BIT_TIMER_AUTO_EN: once started, frames run
// back to back (no IDLE cycle between them) until abort.
// All outputs are decodes of registered state, index and count.
module frame_bit_timer
    import frame_bit_timer_pkg::*;
#(
    parameter int BIT_CYCLES     = 10,
    parameter int BITS_PER_FRAME = 2,
    parameter int IDLE_CYCLES    = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  abort,
    output logic                                  en,
    output logic                                  bit_tick,
    output logic [width_of(BITS_PER_FRAME)-1:0]   bit_idx,
    output logic                                  busy,
    output logic                                  frame_done
);

    localparam int BW = width_of(BITS_PER_FRAME);
    localparam int CW = width_of(max3(BIT_CYCLES, IDLE_CYCLES, 2));

    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
    localparam logic [BW-1:0] IDX_LAST = BW'(BITS_PER_FRAME - 1);
    localparam logic [BW-1:0] IDX_ONE  = BW'(1);

`ifdef FRAME_BIT_TIMER_AUTO_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    // Reject illegal configurations while elaborating.
    if (BIT_CYCLES < 2) begin : g_bad_bit_cycles
        $error("frame_bit_timer: BIT_CYCLES must be >= 2");
    end
    if (BITS_PER_FRAME < 1) begin : g_bad_bits_per_frame
        $error("frame_bit_timer: BITS_PER_FRAME must be >= 1");
    end
    if (IDLE_CYCLES < 0) begin : g_bad_idle_cycles
        $error("frame_bit_timer: IDLE_CYCLES must be >= 0");
    end

    state_t          state_reg;
    state_t          state_next;
    logic [BW-1:0]   bit_idx_reg;
    logic [BW-1:0]   bit_idx_next;

    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_last;
    logic            cnt_tc;
    logic            cnt_clr;
    logic            cnt_en;

    // The counter is held at zero in IDLE so a frame always begins at cnt=0;
    // entering GAP or moving to the next bit relies on its natural wrap.
    assign cnt_clr = abort || (state_reg == ST_IDLE);
    assign cnt_en  = (state_reg != ST_IDLE);

    // Terminal count depends on whether a bit period or the gap is running.
    always_comb begin
        cnt_last = BIT_LAST;
        if (state_reg == ST_GAP) begin
            cnt_last = GAP_LAST;
        end
    end

    mod_counter #(
        .WIDTH (CW)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .last  (cnt_last),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    // State and bit index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            bit_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            bit_idx_reg <= bit_idx_next;
        end
    end

    // Next-state and bit index logic; abort overrides everything.
    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        if (abort) begin
            state_next   = ST_IDLE;
            bit_idx_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    bit_idx_next = '0;
                    if (start) begin
                        state_next = ST_BIT;
                    end
                end
                ST_BIT: begin
                    if (cnt_tc) begin
                        if (bit_idx_reg != IDX_LAST) begin
                            bit_idx_next = bit_idx_reg + IDX_ONE;
                        end else if (IDLE_CYCLES > 0) begin
                            // Index is kept through the gap.
                            state_next = ST_GAP;
                        end else begin
                            bit_idx_next = '0;
                            state_next   = AUTO_EN ? ST_BIT : ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_tc) begin
                        bit_idx_next = '0;
                        state_next   = AUTO_EN ? ST_BIT : ST_IDLE;
                    end
                end
                default: begin
                    state_next   = ST_IDLE;
                    bit_idx_next = '0;
                end
            endcase
        end
    end

    // Output decodes of registered state, index and count only.
    always_comb begin
        en         = (state_reg == ST_BIT);
        busy       = (state_reg != ST_IDLE);
        bit_idx    = bit_idx_reg;
        bit_tick   = (state_reg == ST_BIT) && (cnt == BIT_LAST);
        frame_done = ((state_reg == ST_GAP) && (cnt == GAP_LAST)) ||
                     ((IDLE_CYCLES == 0) && (state_reg == ST_BIT) &&
                      (cnt == BIT_LAST) && (bit_idx_reg == IDX_LAST));
    end

endmodule

// File: tb/tb_frame_bit_timer.sv
// Testbench for frame_bit_timer: a default-parameter instance and a
// (BIT_CYCLES=2, BITS_PER_FRAME=1, IDLE_CYCLES=0) instance, checked cycle by
// cycle against a frame-position reference model, with directed scenarios
// followed by randomized start/abort traffic.
module tb_frame_bit_timer;

`ifdef FRAME_BIT_TIMER_AUTO_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, abort_a, start_b, abort_b;
    logic       en_a, bit_tick_a, busy_a, frame_done_a;
    logic [0:0] bit_idx_a;
    logic       en_b, bit_tick_b, busy_b, frame_done_b;
    logic [0:0] bit_idx_b;

    frame_bit_timer u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_a),
        .abort      (abort_a),
        .en         (en_a),
        .bit_tick   (bit_tick_a),
        .bit_idx    (bit_idx_a),
        .busy       (busy_a),
        .frame_done (frame_done_a)
    );

    frame_bit_timer #(
        .BIT_CYCLES     (2),
        .BITS_PER_FRAME (1),
        .IDLE_CYCLES    (0)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_b),
        .abort      (abort_b),
        .en         (en_b),
        .bit_tick   (bit_tick_b),
        .bit_idx    (bit_idx_b),
        .busy       (busy_b),
        .frame_done (frame_done_b)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a frame is a run of positions 0..len-1 while active.
    int m_bc  [2] = '{10, 2};
    int m_bpf [2] = '{2, 1};
    int m_ic  [2] = '{1, 0};
    int m_act [2];
    int m_pos [2];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int flen(input int d);
        return m_bpf[d] * m_bc[d] + m_ic[d];
    endfunction

    function automatic int exp_en(input int d);
        return (m_act[d] != 0 && m_pos[d] < m_bpf[d] * m_bc[d]) ? 1 : 0;
    endfunction

    function automatic int exp_tick(input int d);
        return (exp_en(d) != 0 && (m_pos[d] % m_bc[d]) == m_bc[d] - 1) ? 1 : 0;
    endfunction

    function automatic int exp_idx(input int d);
        if (m_act[d] == 0) return 0;
        if (m_pos[d] < m_bpf[d] * m_bc[d]) return m_pos[d] / m_bc[d];
        return m_bpf[d] - 1;
    endfunction

    function automatic int exp_done(input int d);
        return (m_act[d] != 0 && m_pos[d] == flen(d) - 1) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0;
            m_pos[d] = 0;
        end
    endtask

    task automatic model_step(input int d, input logic s, input logic a);
        if (a) begin
            m_act[d] = 0;
            m_pos[d] = 0;
        end else if (m_act[d] != 0) begin
            if (m_pos[d] == flen(d) - 1) begin
                m_pos[d] = 0;
                if (!AUTO) m_act[d] = 0;
            end else begin
                m_pos[d] = m_pos[d] + 1;
            end
        end else if (s) begin
            m_act[d] = 1;
            m_pos[d] = 0;
        end
    endtask

    task automatic compare_all(input int d);
        if (d == 0) begin
            chk("a_en",         en_a,         exp_en(0));
            chk("a_bit_tick",   bit_tick_a,   exp_tick(0));
            chk("a_bit_idx",    bit_idx_a,    exp_idx(0));
            chk("a_busy",       busy_a,       m_act[0]);
            chk("a_frame_done", frame_done_a, exp_done(0));
        end else begin
            chk("b_en",         en_b,         exp_en(1));
            chk("b_bit_tick",   bit_tick_b,   exp_tick(1));
            chk("b_bit_idx",    bit_idx_b,    exp_idx(1));
            chk("b_busy",       busy_b,       m_act[1]);
            chk("b_frame_done", frame_done_b, exp_done(1));
        end
    endtask

    // Apply inputs for one cycle, advance the model, compare at the falling edge.
    task automatic tick(input logic sa, input logic aa, input logic sb, input logic ab);
        start_a = sa;
        abort_a = aa;
        start_b = sb;
        abort_b = ab;
        @(posedge clk);
        if (rst_n) begin
            model_step(0, sa, aa);
            model_step(1, sb, ab);
        end
        @(negedge clk);
        compare_all(0);
        compare_all(1);
    endtask

    // Abort instance A in a cycle where it shows neither a tick nor a frame end.
    task automatic abort_a_safely();
        for (int i = 0; i < 4 && (exp_tick(0) != 0 || exp_done(0) != 0); i++)
            tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int busy_cnt, t1, t2, dc, n, prev_en, done_cnt;
        int starts [3];
        logic sa, aa, sb, ab;

        rst_n   = 1'b0;
        start_a = 1'b0;
        abort_a = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare_all(0);
        compare_all(1);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Single default frame plus the minimal-configuration frame.
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        busy_cnt = 0; t1 = -1; t2 = -1; dc = -1;
        for (int c = 1; c <= 21; c++) begin
            if (busy_a) busy_cnt++;
            if (bit_tick_a) begin
                if (t1 < 0) t1 = c;
                else t2 = c;
            end
            if (frame_done_a) dc = c;
            if (c == 10) chk("a_idx_c10", bit_idx_a, 0);
            if (c == 11) chk("a_idx_c11", bit_idx_a, 1);
            if (c == 1) chk("b_en_c1", en_b, 1);
            if (c == 2) begin
                chk("b_en_c2",   en_b,         1);
                chk("b_tick_c2", bit_tick_b,   1);
                chk("b_done_c2", frame_done_b, 1);
            end
            if (c == 3) chk("b_busy_c3", busy_b, AUTO ? 1 : 0);
            tick(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("a_busy_len",  busy_cnt, 21);
        chk("a_tick1_cyc", t1, 10);
        chk("a_tick2_cyc", t2, 20);
        chk("a_done_cyc",  dc, 21);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Abort in cycle 5, restart in cycle 8.
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        chk("abort_busy_c6", busy_a, 0);
        chk("abort_en_c6",   en_a,   0);
        chk("abort_done_c6", frame_done_a, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_done_c7", frame_done_a, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart_en_c9",  en_a,      1);
        chk("restart_idx_c9", bit_idx_a, 0);
        repeat (25) tick(1'b0, 1'b0, 1'b0, 1'b0);
        abort_a_safely();
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Start held high: record the first three frame starts.
        n = 0; prev_en = 0;
        starts[0] = -1; starts[1] = -1; starts[2] = -1;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 46; c++) begin
            if (en_a && prev_en == 0 && n < 3) begin
                starts[n] = c;
                n++;
            end
            prev_en = en_a;
            tick(1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("held_start0", starts[0], 1);
        chk("held_start1", starts[1], AUTO ? 22 : 23);
        chk("held_start2", starts[2], AUTO ? 43 : 45);
        abort_a_safely();
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in cycle 12 of a frame.
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (11) tick(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_en",         en_a,         0);
        chk("rst_bit_tick",   bit_tick_a,   0);
        chk("rst_bit_idx",    bit_idx_a,    0);
        chk("rst_busy",       busy_a,       0);
        chk("rst_frame_done", frame_done_a, 0);
        model_reset();
        repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (30) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            if (frame_done_a) done_cnt++;
        end
        chk("rst_no_done", done_cnt, 0);

        // Randomized start/abort traffic.
        for (int i = 0; i < 3000; i++) begin
            sa = ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 3) == 0);
            aa = ($urandom_range(0, 39) == 0);
            ab = ($urandom_range(0, 29) == 0);
            if (exp_tick(0) != 0 || exp_done(0) != 0) aa = 1'b0;
            if (exp_tick(1) != 0 || exp_done(1) != 0) ab = 1'b0;
            tick(sa, aa, sb, ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
